// File: rtl/bcd_cascade_counter.sv
// bcd_cascade_counter
//   Multi-digit radix-RADIX up/down counter. The digits sit in one packed
//   register and carries/borrows ripple between them within a single cycle.
//   Supports wrap, saturate-at-full-scale and saturate-at-limit modes. It also
//   has a step size, a synchronous parallel load and carry/borrow pulses, so
//   several instances can be chained.
//
// Ports
//   clk          in   rising-edge system clock
//   reset        in   asynchronous active-high reset
//   inc          in   count trigger (level, one step per clock)
//   up_down_sel  in   0 = up, 1 = down
//   step         in   step applied at digit 0 (>= RADIX treated as RADIX-1)
//   carry_in     in   cascade input, one extra unit in the current direction
//   mode         in   00 wrap, 01/11 saturate at full scale, 10 saturate at limit
//   limit        in   packed limit digits (digit 0 in LSBs), clamped per digit
//   load         in   synchronous load of load_val
//   load_val     in   packed load digits, clamped per digit
//   cnt_out      out  registered counter value
//   carry_out    out  registered one-cycle pulse on up-wrap
//   borrow_out   out  registered one-cycle pulse on down-wrap
//   at_limit     out  cnt equals the active ceiling (combinational)
//   is_zero      out  cnt equals zero (combinational)
module bcd_cascade_counter #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 up_down_sel,
  input  logic [DW-1:0]        step,
  input  logic                 carry_in,
  input  logic [1:0]           mode,
  input  logic [DIGITS*DW-1:0] limit,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] cnt_out,
  output logic                 carry_out,
  output logic                 borrow_out,
  output logic                 at_limit,
  output logic                 is_zero
);

  localparam int              W    = DIGITS * DW;
  localparam logic [DW-1:0]   DMAX = DW'(RADIX - 1);
  localparam logic [4:0]      RAD5 = 5'(RADIX);

  // Every digit at RADIX-1, i.e. the full-scale value.
  function automatic logic [W-1:0] fill_max();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DW +: DW] = DMAX;
    end
    return r;
  endfunction

  localparam logic [W-1:0] FS_VAL = fill_max();

  // Clamp each digit of a packed value to RADIX-1.
  function automatic logic [W-1:0] clamp_digits(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*DW +: DW] > DMAX) begin
        r[i*DW +: DW] = DMAX;
      end else begin
        r[i*DW +: DW] = v[i*DW +: DW];
      end
    end
    return r;
  endfunction

  // Ripple add of amt (0..RADIX) into digit 0; MSB of result is the overflow.
  // A digit plus an incoming carry never reaches 2*RADIX, so one subtraction
  // of RADIX per digit is enough.
  function automatic logic [W:0] add_amt(input logic [W-1:0] a, input logic [4:0] amt);
    logic [W-1:0] r;
    logic [4:0]   c;
    logic [4:0]   s;
    r = '0;
    c = amt;
    for (int i = 0; i < DIGITS; i++) begin
      s = 5'(a[i*DW +: DW]) + c;
      if (s >= RAD5) begin
        r[i*DW +: DW] = DW'(s - RAD5);
        c = 5'd1;
      end else begin
        r[i*DW +: DW] = DW'(s);
        c = 5'd0;
      end
    end
    return {c[0], r};
  endfunction

  // Ripple subtract of amt (0..RADIX) from digit 0; MSB of result is the underflow.
  function automatic logic [W:0] sub_amt(input logic [W-1:0] a, input logic [4:0] amt);
    logic [W-1:0] r;
    logic [4:0]   b;
    logic [4:0]   d;
    r = '0;
    b = amt;
    for (int i = 0; i < DIGITS; i++) begin
      d = 5'(a[i*DW +: DW]);
      if (b > d) begin
        r[i*DW +: DW] = DW'(d + RAD5 - b);
        b = 5'd1;
      end else begin
        r[i*DW +: DW] = DW'(d - b);
        b = 5'd0;
      end
    end
    return {b[0], r};
  endfunction

  logic [W-1:0] cnt_r;
  logic         carry_r;
  logic         borrow_r;

  logic [W-1:0] cnt_nxt_s;
  logic         carry_nxt_s;
  logic         borrow_nxt_s;
  logic [W-1:0] lim_s;
  logic [W-1:0] load_cl_s;
  logic [DW-1:0] step_cl_s;
  logic [4:0]   amt_s;
  logic [W:0]   sum_s;
  logic [W:0]   diff_s;
  logic [W-1:0] floor_s;

  // Operand conditioning: clamp digits/step and form the per-cycle amount.
  // Packed digits compare numerically because every digit is below RADIX.
  always_comb begin
    lim_s     = clamp_digits(limit);
    load_cl_s = clamp_digits(load_val);
    if (step > DMAX) begin
      step_cl_s = DMAX;
    end else begin
      step_cl_s = step;
    end
    amt_s  = (inc ? 5'(step_cl_s) : 5'd0) + (carry_in ? 5'd1 : 5'd0);
    sum_s  = add_amt(cnt_r, amt_s);
    diff_s = sub_amt(cnt_r, amt_s);
  end

  // Next-state selection: load > count > clamp > hold.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    carry_nxt_s  = 1'b0;
    borrow_nxt_s = 1'b0;
    floor_s      = diff_s[W] ? '0 : diff_s[W-1:0];
    if (load) begin
      cnt_nxt_s = load_cl_s;
    end else if (amt_s != 5'd0) begin
      if (!up_down_sel) begin
        case (mode)
          2'b00: begin
            cnt_nxt_s   = sum_s[W-1:0];
            carry_nxt_s = sum_s[W];
          end
          2'b10: begin
            // An overflowing sum is above FS, hence above any limit.
            if (sum_s[W] || (sum_s[W-1:0] > lim_s)) begin
              cnt_nxt_s = lim_s;
            end else begin
              cnt_nxt_s = sum_s[W-1:0];
            end
          end
          default: begin
            cnt_nxt_s = sum_s[W] ? FS_VAL : sum_s[W-1:0];
          end
        endcase
      end else begin
        case (mode)
          2'b00: begin
            cnt_nxt_s    = diff_s[W-1:0];
            borrow_nxt_s = diff_s[W];
          end
          2'b10: begin
            cnt_nxt_s = (floor_s > lim_s) ? lim_s : floor_s;
          end
          default: begin
            cnt_nxt_s = floor_s;
          end
        endcase
      end
    end else if ((mode == 2'b10) && (cnt_r > lim_s)) begin
      cnt_nxt_s = lim_s;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= '0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      carry_r  <= carry_nxt_s;
      borrow_r <= borrow_nxt_s;
    end
  end

  // Output mapping; status flags follow the current mode/limit directly.
  always_comb begin
    cnt_out    = cnt_r;
    carry_out  = carry_r;
    borrow_out = borrow_r;
    at_limit   = (cnt_r == ((mode == 2'b10) ? lim_s : FS_VAL));
    is_zero    = (cnt_r == '0);
  end

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Self-checking bench for bcd_cascade_counter (DIGITS=2, RADIX=10).
// The reference model keeps the count as a plain integer and applies the
// counting rules with ordinary arithmetic.
module tb_bcd_cascade_counter;

  localparam int DIGITS = 2;
  localparam int RADIX  = 10;
  localparam int DW     = 4;
  localparam int W      = DIGITS * DW;
  localparam int FS     = RADIX ** DIGITS - 1;

  logic          clk;
  logic          reset;
  logic          inc;
  logic          up_down_sel;
  logic [DW-1:0] step;
  logic          carry_in;
  logic [1:0]    mode;
  logic [W-1:0]  limit;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  cnt_out;
  logic          carry_out;
  logic          borrow_out;
  logic          at_limit;
  logic          is_zero;

  int m_cnt;
  int m_carry;
  int m_borrow;
  int checks;
  int errors;

  bcd_cascade_counter #(.DIGITS(DIGITS), .RADIX(RADIX), .DW(DW)) dut (
    .clk(clk), .reset(reset), .inc(inc), .up_down_sel(up_down_sel),
    .step(step), .carry_in(carry_in), .mode(mode), .limit(limit),
    .load(load), .load_val(load_val), .cnt_out(cnt_out),
    .carry_out(carry_out), .borrow_out(borrow_out),
    .at_limit(at_limit), .is_zero(is_zero)
  );

  always #5 clk = ~clk;

  // Packed digits -> integer, clamping each digit to RADIX-1.
  function automatic int dec(input logic [W-1:0] v);
    int r;
    int d;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(v[i*DW +: DW]);
      if (d > RADIX - 1) d = RADIX - 1;
      r = r * RADIX + d;
    end
    return r;
  endfunction

  // Integer -> packed digits.
  function automatic logic [W-1:0] enc(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DW +: DW] = DW'(t % RADIX);
      t = t / RADIX;
    end
    return r;
  endfunction

  task automatic check_all(input string tag);
    logic [W-1:0] e_cnt;
    logic e_lim;
    e_cnt = enc(m_cnt);
    e_lim = (mode == 2'b10) ? (m_cnt == dec(limit)) : (m_cnt == FS);
    checks++;
    assert (cnt_out === e_cnt) else begin
      errors++; $error("FAIL %s cnt_out got %h want %h", tag, cnt_out, e_cnt);
    end
    checks++;
    assert (carry_out === 1'(m_carry)) else begin
      errors++; $error("FAIL %s carry_out got %b want %0d", tag, carry_out, m_carry);
    end
    checks++;
    assert (borrow_out === 1'(m_borrow)) else begin
      errors++; $error("FAIL %s borrow_out got %b want %0d", tag, borrow_out, m_borrow);
    end
    checks++;
    assert (at_limit === e_lim) else begin
      errors++; $error("FAIL %s at_limit got %b want %b", tag, at_limit, e_lim);
    end
    checks++;
    assert (is_zero === 1'(m_cnt == 0)) else begin
      errors++; $error("FAIL %s is_zero got %b want %0d", tag, is_zero, (m_cnt == 0));
    end
  endtask

  // Directed spot check against a literal expected count.
  task automatic check_val(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (cnt_out === exp) else begin
      errors++; $error("FAIL %s literal cnt_out got %h want %h", tag, cnt_out, exp);
    end
  endtask

  // Predict the effect of the coming edge, clock it, then compare.
  task automatic do_edge(input string tag);
    int amt;
    int lim;
    int nv;
    int s;
    lim = dec(limit);
    s = int'(step);
    if (s > RADIX - 1) s = RADIX - 1;
    amt = (inc ? s : 0) + (carry_in ? 1 : 0);
    m_carry = 0;
    m_borrow = 0;
    if (load) begin
      m_cnt = dec(load_val);
    end else if (amt > 0) begin
      if (!up_down_sel) begin
        nv = m_cnt + amt;
        if (mode == 2'b00) begin
          m_carry = (nv > FS) ? 1 : 0;
          m_cnt = nv % (FS + 1);
        end else if (mode == 2'b10) begin
          m_cnt = (nv < lim) ? nv : lim;
        end else begin
          m_cnt = (nv < FS) ? nv : FS;
        end
      end else begin
        nv = m_cnt - amt;
        if (mode == 2'b00) begin
          m_borrow = (nv < 0) ? 1 : 0;
          m_cnt = (nv + FS + 1) % (FS + 1);
        end else begin
          if (nv < 0) nv = 0;
          if (mode == 2'b10 && nv > lim) nv = lim;
          m_cnt = nv;
        end
      end
    end else if (mode == 2'b10 && m_cnt > lim) begin
      m_cnt = lim;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    inc = 1'b0; carry_in = 1'b0; load = 1'b0; up_down_sel = 1'b0; step = 4'd0;
  endtask

  task automatic do_load(input logic [W-1:0] v, input string tag);
    idle();
    load = 1'b1; load_val = v;
    do_edge(tag);
    load = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_cnt = 0; m_carry = 0; m_borrow = 0;
    clk = 1'b0; reset = 1'b1;
    mode = 2'b00; limit = 8'h00; load_val = 8'h00;
    idle();
    #12;
    check_all("reset_state");
    reset = 1'b0;

    // 1. reset mid-count
    do_load(8'h57, "load57");
    inc = 1'b1; step = 4'd0;
    reset = 1'b1; #1;
    m_cnt = 0; m_carry = 0; m_borrow = 0;
    check_all("reset_mid");
    check_val("reset_mid", 8'h00);
    reset = 1'b0; idle();

    // 2. wrap up
    do_load(8'h98, "load98");
    inc = 1'b1; step = 4'd2; mode = 2'b00;
    do_edge("wrap_up");
    check_val("wrap_up", 8'h00);
    step = 4'd1;
    do_edge("wrap_next");
    check_val("wrap_next", 8'h01);

    // 3. ripple with cascade, then down wrap
    do_load(8'h19, "load19");
    inc = 1'b1; step = 4'd9; carry_in = 1'b1;
    do_edge("ripple_cin");
    check_val("ripple_cin", 8'h29);
    carry_in = 1'b0; up_down_sel = 1'b1;
    do_edge("down1"); check_val("down1", 8'h20);
    do_edge("down2"); check_val("down2", 8'h11);
    do_edge("down3"); check_val("down3", 8'h02);
    step = 4'd3;
    do_edge("down_wrap"); check_val("down_wrap", 8'h99);
    idle();
    do_edge("borrow_clear");

    // 4. saturate
    mode = 2'b01;
    do_load(8'h97, "load97");
    inc = 1'b1; step = 4'd5;
    do_edge("sat_up"); check_val("sat_up", 8'h99);
    do_load(8'h03, "load03");
    inc = 1'b1; step = 4'd5; up_down_sel = 1'b1;
    do_edge("sat_down"); check_val("sat_down", 8'h00);
    mode = 2'b11; up_down_sel = 1'b0; step = 4'd15;
    do_edge("mode11_up");

    // 5. limit mode
    mode = 2'b10; limit = 8'h42;
    do_load(8'h39, "load39");
    inc = 1'b1; step = 4'd5;
    do_edge("lim_up"); check_val("lim_up", 8'h42);
    idle(); limit = 8'h30;
    do_edge("lim_change"); check_val("lim_change", 8'h30);
    do_load(8'h55, "lim_load55"); check_val("lim_load55", 8'h55);
    do_edge("lim_clamp"); check_val("lim_clamp", 8'h30);
    limit = 8'h00;
    do_edge("lim_zero");
    inc = 1'b1; step = 4'd0; carry_in = 1'b0;
    limit = 8'h50;
    do_edge("inc_step0_idle");

    // 6. clamping and priority
    mode = 2'b00;
    do_load(8'hFC, "load_clamp"); check_val("load_clamp", 8'h99);
    do_load(8'h00, "load00");
    inc = 1'b1; step = 4'd12;
    do_edge("step_clamp"); check_val("step_clamp", 8'h09);
    load = 1'b1; load_val = 8'h45;
    do_edge("load_prio"); check_val("load_prio", 8'h45);
    idle();

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      inc         = 1'($urandom_range(0, 3) != 0);
      up_down_sel = 1'($urandom_range(0, 1));
      step        = 4'($urandom_range(0, 15));
      carry_in    = 1'($urandom_range(0, 3) == 0);
      mode        = 2'($urandom_range(0, 3));
      limit       = 8'($urandom_range(0, 255));
      load        = 1'($urandom_range(0, 9) == 0);
      load_val    = 8'($urandom_range(0, 255));
      do_edge("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
